// File: rtl/branch_history_table.sv
// Bimodal branch predictor: 2-bit saturating counters indexed by PC, with EX-stage training and redirect.
// Optional BHT_STATS_EN adds saturating branch/mispredict statistics outputs.
module branch_history_table #(
  parameter int unsigned INDEX_BITS = 4,
  parameter int unsigned PC_WIDTH   = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PC_WIDTH-1:0] fetch_pc,
  output logic                prediction,
  input  logic                ex_branch,
  input  logic [PC_WIDTH-1:0] ex_pc,
  input  logic                ex_taken,
  input  logic                ex_prediction,
  input  logic [PC_WIDTH-1:0] ex_target,
  output logic                mispredict,
  output logic [PC_WIDTH-1:0] redirect_pc
`ifdef BHT_STATS_EN
  ,
  output logic [31:0]         stat_branches,
  output logic [31:0]         stat_mispredicts
`endif
);

  localparam int unsigned ENTRIES  = 1 << INDEX_BITS;
  localparam int unsigned STAT_W   = 32;
  localparam logic [1:0]  CNT_SNT  = 2'b00;
  localparam logic [1:0]  CNT_WNT  = 2'b01;
  localparam logic [1:0]  CNT_ST   = 2'b11;

  logic [1:0]            counter_q [ENTRIES];
  logic [1:0]            counter_d [ENTRIES];
  logic [INDEX_BITS-1:0] fetch_idx;
  logic [INDEX_BITS-1:0] upd_idx;
  logic                  unused_fetch_bits;

  assign fetch_idx = fetch_pc[INDEX_BITS+1:2];
  assign upd_idx   = ex_pc[INDEX_BITS+1:2];

  // Low byte-offset bits and bits above the index alias by design.
  assign unused_fetch_bits = ^{fetch_pc[1:0], fetch_pc[PC_WIDTH-1:INDEX_BITS+2]};

  // Lookup reads the registered table, so a same-cycle update is not bypassed.
  assign prediction  = counter_q[fetch_idx][1];
  assign mispredict  = ex_branch & (ex_taken ^ ex_prediction);
  assign redirect_pc = ex_taken ? ex_target : ex_pc + PC_WIDTH'(4);

  // Saturating training from the stored counter, not the carried prediction.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      counter_d[i] = counter_q[i];
    end
    if (ex_branch) begin
      if (ex_taken) begin
        if (counter_q[upd_idx] != CNT_ST) begin
          counter_d[upd_idx] = counter_q[upd_idx] + 2'd1;
        end
      end else begin
        if (counter_q[upd_idx] != CNT_SNT) begin
          counter_d[upd_idx] = counter_q[upd_idx] - 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        counter_q[i] <= CNT_WNT;
      end
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        counter_q[i] <= counter_d[i];
      end
    end
  end

`ifdef BHT_STATS_EN
  logic [STAT_W-1:0] stat_branches_q;
  logic [STAT_W-1:0] stat_branches_d;
  logic [STAT_W-1:0] stat_mispredicts_q;
  logic [STAT_W-1:0] stat_mispredicts_d;

  // Event counters stick at all-ones instead of wrapping.
  always_comb begin
    stat_branches_d    = stat_branches_q;
    stat_mispredicts_d = stat_mispredicts_q;
    if (ex_branch && (stat_branches_q != '1)) begin
      stat_branches_d = stat_branches_q + STAT_W'(1);
    end
    if (mispredict && (stat_mispredicts_q != '1)) begin
      stat_mispredicts_d = stat_mispredicts_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule
